// File: rtl/relu_requant.sv
// ReLU, right-shift requantisation and saturation with raster end-of-row/frame tagging.
// Build option: define RELU_ROUND_EN for round-half-up; truncation otherwise.
module relu_requant #(
   parameter int ACC_WIDTH  = 20,
   parameter int DATA_WIDTH = 8,
   parameter int SHIFT      = 4,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  valid_in,
   input  logic [ACC_WIDTH-1:0]  data_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  eol_out,
   output logic                  eof_out
);

   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = $clog2(IMG_H + 1);
   localparam logic [CW-1:0]      COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]      ROW_LAST = RW'(IMG_H - 1);
   localparam logic [ACC_WIDTH:0] SAT_MAX  = (ACC_WIDTH + 1)'((1 << DATA_WIDTH) - 1);
`ifdef RELU_ROUND_EN
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [ACC_WIDTH:0] RND = (SHIFT > 0) ?
      ((ACC_WIDTH + 1)'(1) << RND_SH) : (ACC_WIDTH + 1)'(0);
`else
   localparam logic [ACC_WIDTH:0] RND = (ACC_WIDTH + 1)'(0);
`endif

   logic [CW-1:0]         col_r;
   logic [RW-1:0]         row_r;
   logic                  s1_valid_r;
   logic [ACC_WIDTH:0]    s1_val_r;
   logic                  s1_eol_r;
   logic                  s1_eof_r;
   logic [ACC_WIDTH:0]    sum_s;
   logic [ACC_WIDTH:0]    relu_s;
   logic [DATA_WIDTH-1:0] sat_s;
   logic                  col_last_s;
   logic                  row_last_s;

   // ReLU and rounded shift; the extra sum bit absorbs the rounding carry.
   always_comb begin
      sum_s  = {data_in[ACC_WIDTH-1], data_in} + RND;
      relu_s = '0;
      if (data_in[ACC_WIDTH-1]) begin
         relu_s = '0;
      end else begin
         relu_s = sum_s >> SHIFT;
      end
   end

   // Clamp to the unsigned pixel range.
   always_comb begin
      sat_s = '0;
      if (s1_val_r > SAT_MAX) begin
         sat_s = '1;
      end else begin
         sat_s = s1_val_r[DATA_WIDTH-1:0];
      end
   end

   // Raster position decode.
   always_comb begin
      col_last_s = (col_r == COL_LAST);
      row_last_s = (row_r == ROW_LAST);
   end

   // Column/row counters advance on each accepted pixel.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         col_r <= '0;
         row_r <= '0;
      end else if (valid_in) begin
         if (col_last_s) begin
            col_r <= '0;
            if (row_last_s) row_r <= '0;
            else            row_r <= row_r + RW'(1);
         end else begin
            col_r <= col_r + CW'(1);
         end
      end
   end

   // Stage 1: rescaled value and position flags of the accepted pixel.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         s1_valid_r <= 1'b0;
         s1_val_r   <= '0;
         s1_eol_r   <= 1'b0;
         s1_eof_r   <= 1'b0;
      end else begin
         s1_valid_r <= valid_in;
         if (valid_in) begin
            s1_val_r <= relu_s;
            s1_eol_r <= col_last_s;
            s1_eof_r <= col_last_s && row_last_s;
         end
      end
   end

   // Stage 2: saturated output; data holds and flags drop during bubbles.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         eol_out   <= 1'b0;
         eof_out   <= 1'b0;
      end else begin
         valid_out <= s1_valid_r;
         if (s1_valid_r) begin
            data_out <= sat_s;
            eol_out  <= s1_eol_r;
            eof_out  <= s1_eof_r;
         end else begin
            eol_out  <= 1'b0;
            eof_out  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_relu_requant.sv
// Scoreboard bench for relu_requant: three instances (28x28/SHIFT=4, 4x2/SHIFT=4, 4x2/SHIFT=0).
module tb_relu_requant;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [2:0]        vin = 3'b000;
   logic [19:0]       din [3];
   logic [2:0]        vout, eol, eof;
   logic [7:0]        dout [3];
   logic [2:0]        vd1, vd2;
   logic [7:0]        last_d [3];
   logic [9:0]        q0[$], q1[$], q2[$];
   int                checks = 0;
   int                errors = 0;
   int                eol_cnt = 0;
   int                eof_cnt = 0;
   int                col [3];
   int                row [3];
   int                img_w [3];
   int                img_h [3];

`ifdef RELU_ROUND_EN
   localparam logic [7:0] E104 = 8'd7;
`else
   localparam logic [7:0] E104 = 8'd6;
`endif

   always #5 clk = ~clk;

   relu_requant #(.ACC_WIDTH(20), .DATA_WIDTH(8), .SHIFT(4), .IMG_W(28), .IMG_H(28)) dut_a (
      .Clk(clk), .Rst(rst), .valid_in(vin[0]), .data_in(din[0]),
      .valid_out(vout[0]), .data_out(dout[0]), .eol_out(eol[0]), .eof_out(eof[0]));
   relu_requant #(.ACC_WIDTH(20), .DATA_WIDTH(8), .SHIFT(4), .IMG_W(4), .IMG_H(2)) dut_b (
      .Clk(clk), .Rst(rst), .valid_in(vin[1]), .data_in(din[1]),
      .valid_out(vout[1]), .data_out(dout[1]), .eol_out(eol[1]), .eof_out(eof[1]));
   relu_requant #(.ACC_WIDTH(20), .DATA_WIDTH(8), .SHIFT(0), .IMG_W(4), .IMG_H(2)) dut_c (
      .Clk(clk), .Rst(rst), .valid_in(vin[2]), .data_in(din[2]),
      .valid_out(vout[2]), .data_out(dout[2]), .eol_out(eol[2]), .eof_out(eof[2]));

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed %0h expected %0h at %0t", tag, k, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_pix(input int x, input int sh);
      int r;
      int v;
      if (x < 0) return 8'd0;
      r = 0;
`ifdef RELU_ROUND_EN
      if (sh > 0) r = 1 << (sh - 1);
`endif
      v = (x + r) >>> sh;
      if (v > 255) return 8'd255;
      return v[7:0];
   endfunction

   task automatic push(input int k, input logic [9:0] e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pop(input int k, output logic ok, output logic [9:0] e);
      ok = 1'b0;
      e  = 10'd0;
      case (k)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // Expected valid_out: input valid delayed by two clocks, cleared by reset.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         vd1 <= 3'b000;
         vd2 <= 3'b000;
      end else begin
         vd1 <= vin;
         vd2 <= vd1;
      end
   end

   task automatic mon(input int k, input logic v, input logic [7:0] d, input logic e,
                      input logic f, input logic ev);
      logic       ok;
      logic [9:0] x;
      if (!rst) begin
         check("rst_valid", k, {31'd0, v}, 32'd0);
         check("rst_data", k, {24'd0, d}, 32'd0);
         check("rst_flags", k, {30'd0, e, f}, 32'd0);
         last_d[k] = 8'd0;
         case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
         endcase
      end else begin
         check("valid_latency", k, {31'd0, v}, {31'd0, ev});
         if (v) begin
            pop(k, ok, x);
            check("sb_nonempty", k, {31'd0, ok}, 32'd1);
            if (ok) begin
               check("data", k, {24'd0, d}, {24'd0, x[7:0]});
               check("eol", k, {31'd0, e}, {31'd0, x[8]});
               check("eof", k, {31'd0, f}, {31'd0, x[9]});
            end
            last_d[k] = d;
            if (k == 0) begin
               if (e) eol_cnt++;
               if (f) eof_cnt++;
            end
         end else begin
            check("hold_data", k, {24'd0, d}, {24'd0, last_d[k]});
            check("idle_flags", k, {30'd0, e, f}, 32'd0);
         end
      end
   endtask

   always @(negedge clk) mon(0, vout[0], dout[0], eol[0], eof[0], vd2[0]);
   always @(negedge clk) mon(1, vout[1], dout[1], eol[1], eof[1], vd2[1]);
   always @(negedge clk) mon(2, vout[2], dout[2], eol[2], eof[2], vd2[2]);

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         col[i] = 0;
         row[i] = 0;
      end
   endtask

   task automatic send(input int k, input int x, input logic [7:0] e);
      logic le;
      logic lf;
      le = (col[k] == img_w[k] - 1);
      lf = le && (row[k] == img_h[k] - 1);
      push(k, {lf, le, e});
      if (le) begin
         col[k] = 0;
         row[k] = lf ? 0 : row[k] + 1;
      end else begin
         col[k] = col[k] + 1;
      end
      vin[k] = 1'b1;
      din[k] = x[19:0];
      cyc();
      vin[k] = 1'b0;
   endtask

   initial begin
      int x;
      int eol0;
      int eof0;
      img_w = '{28, 4, 4};
      img_h = '{28, 2, 2};
      for (int i = 0; i < 3; i++) begin
         din[i] = 20'd0;
         last_d[i] = 8'd0;
      end
      model_reset();
      idle(3);
      rst = 1'b1;
      idle(2);

      // Rounding, ReLU and saturation at SHIFT=4.
      send(0, 104, E104);
      send(0, 100, 8'd6);
      send(0, -50, 8'd0);
      send(0, -(1 << 19), 8'd0);
      send(0, 5000, 8'd255);
      send(0, 4087, 8'd255);
      send(0, 4071, 8'd254);

      // SHIFT=0 is a pure clamp.
      send(2, 255, 8'd255);
      send(2, 256, 8'd255);
      send(2, 7, 8'd7);
      send(2, -1, 8'd0);
      send(2, 200, 8'd200);
      idle(4);

      // Raster flags at 4x2: nine back-to-back pixels.
      for (int i = 0; i < 9; i++) send(1, 16 * i, i[7:0]);
      idle(3);

      // Bubbles: pattern 1,0,0,1,1.
      send(1, 16, 8'd1);
      idle(2);
      send(1, 32, 8'd2);
      send(1, 48, 8'd3);
      idle(4);

      // Reset while two pixels are in flight.
      send(1, 64, 8'd4);
      send(1, 80, 8'd5);
      rst = 1'b0;
      model_reset();
      #1;
      check("async_rst_valid", 1, {31'd0, vout[1]}, 32'd0);
      check("async_rst_data", 1, {24'd0, dout[1]}, 32'd0);
      check("async_rst_flags", 1, {30'd0, eol[1], eof[1]}, 32'd0);
      cyc();
      rst = 1'b1;
      idle(3);
      for (int i = 0; i < 5; i++) send(1, 16 * (i + 1), 8'(i + 1));
      idle(4);

      // Sustained random stream: two full 28x28 frames.
      eol0 = eol_cnt;
      eof0 = eof_cnt;
      for (int i = 0; i < 2 * 28 * 28; i++) begin
         x = int'($urandom_range(7000)) - 1000;
         vin[0] = 1'b1;
         send(0, x, exp_pix(x, 4));
      end
      idle(4);
      check("eol_pulses", 0, eol_cnt - eol0, 32'd56);
      check("eof_pulses", 0, eof_cnt - eof0, 32'd2);
      check("sb_drained0", 0, q0.size(), 32'd0);
      check("sb_drained1", 1, q1.size(), 32'd0);
      check("sb_drained2", 2, q2.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
